// File: rtl/stream_upsizer_pkg.sv
// Shared helpers for the stream upsizer: width arithmetic used by the lane counter.
package stream_upsizer_pkg;

  // Counter width for n states, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_upsizer.sv
// Narrow-to-wide valid/ready converter: packs RATIO beats into one registered word,
// with w_last closing a word early and r_keep marking populated lanes.
module stream_upsizer
  import stream_upsizer_pkg::*;
#(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      w_valid,
  output logic                      w_ready,
  input  logic [IN_WIDTH-1:0]       w_data,
  input  logic                      w_last,
  output logic                      r_valid,
  input  logic                      r_ready,
  output logic [IN_WIDTH*RATIO-1:0] r_data,
  output logic [RATIO-1:0]          r_keep,
  output logic                      r_last
);

  localparam int CW = clog2_min1(RATIO);
  localparam int OW = IN_WIDTH * RATIO;

  logic [CW-1:0]    cnt_q,     cnt_d;
  logic             r_valid_q, r_valid_d;
  logic [OW-1:0]    r_data_q,  r_data_d;
  logic [RATIO-1:0] r_keep_q,  r_keep_d;
  logic             r_last_q,  r_last_d;
  logic             accept;

  // Combinational from r_ready so a full word can leave while the next beat enters.
  assign w_ready = !r_valid_q || r_ready;
  assign accept  = w_valid && w_ready;

  always_comb begin
    cnt_d     = cnt_q;
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    r_keep_d  = r_keep_q;
    r_last_d  = r_last_q;

    if (r_valid_q && r_ready) r_valid_d = 1'b0;

    if (accept) begin
      // Lane 0 opens a fresh word, so stale lanes from the previous word are wiped.
      if (cnt_q == '0) begin
        r_data_d = '0;
        r_keep_d = '0;
      end
      for (int i = 0; i < RATIO; i++) begin
        if (cnt_q == CW'(i)) begin
          r_data_d[i*IN_WIDTH +: IN_WIDTH] = w_data;
          r_keep_d[i]                      = 1'b1;
        end
      end
      if (cnt_q == CW'(RATIO - 1) || w_last) begin
        r_valid_d = 1'b1;
        r_last_d  = w_last;
        cnt_d     = '0;
      end else begin
        cnt_d     = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_keep_q  <= '0;
      r_last_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_keep_q  <= r_keep_d;
      r_last_q  <= r_last_d;
    end
  end

  assign r_valid = r_valid_q;
  assign r_data  = r_data_q;
  assign r_keep  = r_keep_q;
  assign r_last  = r_last_q;

endmodule

// File: tb/tb_stream_upsizer.sv
// Directed bench for stream_upsizer: per-cycle vector table for RATIO=4, plus
// hand sequences for mid-packet reset and the RATIO=1 pass-through case.
module tb_stream_upsizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_valid, w_last, r_ready;
  logic [7:0]  w_data;
  logic        w_ready, r_valid, r_last;
  logic [31:0] r_data;
  logic [3:0]  r_keep;

  logic        w_valid1, w_last1, r_ready1;
  logic [7:0]  w_data1;
  logic        w_ready1, r_valid1, r_last1;
  logic [7:0]  r_data1;
  logic [0:0]  r_keep1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_upsizer #(.IN_WIDTH(8), .RATIO(4)) u_dut (
    .clk(clk), .rst(rst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_keep(r_keep), .r_last(r_last)
  );

  stream_upsizer #(.IN_WIDTH(8), .RATIO(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .w_valid(w_valid1), .w_ready(w_ready1), .w_data(w_data1), .w_last(w_last1),
    .r_valid(r_valid1), .r_ready(r_ready1), .r_data(r_data1), .r_keep(r_keep1), .r_last(r_last1)
  );

  // One row = one clock cycle: inputs driven and outputs expected during that cycle.
  typedef struct {
    logic        wv;
    logic [7:0]  wd;
    logic        wl;
    logic        rr;
    logic        e_wr;
    logic        e_rv;
    logic        e_chk;
    logic [31:0] e_data;
    logic [3:0]  e_keep;
    logic        e_last;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic wv, input logic [7:0] wd, input logic wl, input logic rr,
                     input logic e_wr, input logic e_rv, input logic e_chk,
                     input logic [31:0] e_data, input logic [3:0] e_keep, input logic e_last);
    vec_t v;
    v.wv = wv; v.wd = wd; v.wl = wl; v.rr = rr;
    v.e_wr = e_wr; v.e_rv = e_rv; v.e_chk = e_chk;
    v.e_data = e_data; v.e_keep = e_keep; v.e_last = e_last;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    w_valid = 1'b1; w_data = d; w_last = l;
    tick();
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    w_valid = 0; w_data = 0; w_last = 0; r_ready = 1;
    w_valid1 = 0; w_data1 = 0; w_last1 = 0; r_ready1 = 1;

    //   wv  wd     wl rr   wr rv chk data          keep    last
    row(0, 8'h00, 0, 1,   1, 0, 1, 32'h00000000, 4'h0, 0); // reset state
    row(1, 8'h11, 0, 1,   1, 0, 0, 32'h0,        4'h0, 0);
    row(1, 8'h22, 0, 1,   1, 0, 0, 32'h0,        4'h0, 0);
    row(1, 8'h33, 0, 1,   1, 0, 0, 32'h0,        4'h0, 0);
    row(1, 8'h44, 1, 1,   1, 0, 0, 32'h0,        4'h0, 0);
    row(1, 8'hAA, 0, 1,   1, 1, 1, 32'h44332211, 4'hF, 1); // drain + accept
    row(1, 8'hBB, 1, 1,   1, 0, 0, 32'h0,        4'h0, 0);
    row(1, 8'hCC, 0, 0,   0, 1, 1, 32'h0000BBAA, 4'h3, 1); // short word, stalled
    row(1, 8'hCC, 0, 1,   1, 1, 1, 32'h0000BBAA, 4'h3, 1); // CC into lane 0
    row(1, 8'hDD, 1, 1,   1, 0, 0, 32'h0,        4'h0, 0);
    row(0, 8'h00, 0, 1,   1, 1, 1, 32'h0000DDCC, 4'h3, 1);
    row(0, 8'h00, 0, 1,   1, 0, 0, 32'h0,        4'h0, 0);
    row(1, 8'h11, 0, 1,   1, 0, 0, 32'h0,        4'h0, 0); // continuous 8 beats
    row(1, 8'h22, 0, 1,   1, 0, 0, 32'h0,        4'h0, 0);
    row(1, 8'h33, 0, 1,   1, 0, 0, 32'h0,        4'h0, 0);
    row(1, 8'h44, 0, 1,   1, 0, 0, 32'h0,        4'h0, 0);
    row(1, 8'h55, 0, 1,   1, 1, 1, 32'h44332211, 4'hF, 0);
    row(1, 8'h66, 0, 1,   1, 0, 0, 32'h0,        4'h0, 0);
    row(1, 8'h77, 0, 1,   1, 0, 0, 32'h0,        4'h0, 0);
    row(1, 8'h88, 1, 1,   1, 0, 0, 32'h0,        4'h0, 0);
    row(0, 8'h00, 0, 1,   1, 1, 1, 32'h88776655, 4'hF, 1);
    row(0, 8'h00, 0, 1,   1, 0, 0, 32'h0,        4'h0, 0);
    row(1, 8'h01, 0, 1,   1, 0, 0, 32'h0,        4'h0, 0); // full word then stall
    row(1, 8'h02, 0, 1,   1, 0, 0, 32'h0,        4'h0, 0);
    row(1, 8'h03, 0, 1,   1, 0, 0, 32'h0,        4'h0, 0);
    row(1, 8'h04, 0, 1,   1, 0, 0, 32'h0,        4'h0, 0);
    row(1, 8'h10, 0, 0,   0, 1, 1, 32'h04030201, 4'hF, 0);
    row(1, 8'h10, 0, 0,   0, 1, 1, 32'h04030201, 4'hF, 0);
    row(1, 8'h10, 0, 0,   0, 1, 1, 32'h04030201, 4'hF, 0);
    row(1, 8'h10, 0, 1,   1, 1, 1, 32'h04030201, 4'hF, 0);
    row(1, 8'h20, 1, 1,   1, 0, 0, 32'h0,        4'h0, 0);
    row(0, 8'h00, 0, 1,   1, 1, 1, 32'h00002010, 4'h3, 1);
    row(0, 8'h00, 0, 1,   1, 0, 0, 32'h0,        4'h0, 0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      w_valid = vecs[i].wv; w_data = vecs[i].wd; w_last = vecs[i].wl; r_ready = vecs[i].rr;
      #1;
      chk($sformatf("row%0d w_ready", i), {31'b0, w_ready}, {31'b0, vecs[i].e_wr});
      chk($sformatf("row%0d r_valid", i), {31'b0, r_valid}, {31'b0, vecs[i].e_rv});
      if (vecs[i].e_chk) begin
        chk($sformatf("row%0d r_data", i), r_data, vecs[i].e_data);
        chk($sformatf("row%0d r_keep", i), {28'b0, r_keep}, {28'b0, vecs[i].e_keep});
        chk($sformatf("row%0d r_last", i), {31'b0, r_last}, {31'b0, vecs[i].e_last});
      end
      @(posedge clk);
      #1;
    end
    w_valid = 0; w_last = 0; r_ready = 1;

    // Mid-packet reset: two lanes accepted, then dropped.
    beat(8'hE1, 0);
    beat(8'hE2, 0);
    rst = 1'b1;
    #1;
    chk("rst r_valid", {31'b0, r_valid}, 32'h0);
    chk("rst r_data",  r_data, 32'h0);
    chk("rst r_keep",  {28'b0, r_keep}, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("post-rst idle r_valid", {31'b0, r_valid}, 32'h0);
    beat(8'h01, 0);
    beat(8'h02, 0);
    beat(8'h03, 0);
    chk("post-rst partial r_valid", {31'b0, r_valid}, 32'h0);
    beat(8'h04, 0);
    chk("post-rst r_valid", {31'b0, r_valid}, 32'h1);
    chk("post-rst r_data",  r_data, 32'h04030201);
    chk("post-rst r_keep",  {28'b0, r_keep}, 32'hF);
    chk("post-rst r_last",  {31'b0, r_last}, 32'h0);
    tick();
    chk("post-rst drained", {31'b0, r_valid}, 32'h0);

    // Single-beat packet in RATIO=4: lane 0 only.
    beat(8'h77, 1);
    chk("single r_data", r_data, 32'h00000077);
    chk("single r_keep", {28'b0, r_keep}, 32'h1);
    chk("single r_last", {31'b0, r_last}, 32'h1);
    tick();

    // RATIO=1 acts as a forward register.
    chk("r1 idle r_valid", {31'b0, r_valid1}, 32'h0);
    w_valid1 = 1; w_data1 = 8'h5A; w_last1 = 1;
    tick();
    w_valid1 = 1; w_data1 = 8'hC3; w_last1 = 0;
    chk("r1 r_valid", {31'b0, r_valid1}, 32'h1);
    chk("r1 r_data",  {24'b0, r_data1}, 32'h5A);
    chk("r1 r_keep",  {31'b0, r_keep1}, 32'h1);
    chk("r1 r_last",  {31'b0, r_last1}, 32'h1);
    tick();
    w_valid1 = 0;
    chk("r1 b2 r_data", {24'b0, r_data1}, 32'hC3);
    chk("r1 b2 r_last", {31'b0, r_last1}, 32'h0);
    chk("r1 b2 r_keep", {31'b0, r_keep1}, 32'h1);
    tick();
    chk("r1 drained", {31'b0, r_valid1}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
